ahb_sram_responder: RTL

AHB-Lite responder (slave end) that sits on one ahbSlaveInterface port of the interconnect and is backed by a byte-addressable SRAM. It accepts address phases, inserts a configurable number of wait states, completes reads and writes with byte-lane enables, and returns the two-cycle ERROR response for illegal transfers. It is the bench and system target for every interconnect slave port.

---
 rtl/ahb_sram_responder_pkg.sv | 40 ++++
 rtl/ahb_sram_responder_if.sv | 30 +++
 rtl/ahb_sram_byte_mem.sv | 35 +++
 rtl/ahb_sram_responder.sv | 119 +++++++++++
 4 files changed

// File: rtl/ahb_sram_responder_pkg.sv
// Shared AHB-Lite encodings, responder state enum and byte-lane decode
// used by the SRAM responder and its memory.
package ahb_sram_responder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } rsp_state_e;

    // Little-endian lane mask; only meaningful for legal size/alignment pairs.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: byte_lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite slave-port bundle between the interconnect (master modport)
// and the SRAM responder (slave modport).
interface ahb_sram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hselx;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyout;
    logic [DATA_WIDTH-1:0] hrdata;
    logic [1:0]            hresp;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_sram_byte_mem.sv
// Single-port MEM_DEPTH x 32 SRAM with per-byte write enables,
// asynchronous read and synchronous clear on reset.
module ahb_sram_byte_mem #(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // One array per byte lane keeps each lane's writer independent.
            logic [7:0] lane_mem [MEM_DEPTH];

            always_ff @(posedge hclk) begin
                if (hreset) begin
                    for (int i = 0; i < MEM_DEPTH; i++) begin
                        lane_mem[i] <= '0;
                    end
                end else if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: address-phase capture, legality check, wait-state
// insertion and two-cycle ERROR response in front of a byte-lane SRAM.
module ahb_sram_responder
    import ahb_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLAVE_SEL_BITS = 1,
    parameter int MEM_DEPTH      = 1024,
    parameter int WAIT_STATES    = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    ahb_sram_responder_if.slave  bus
);

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam int         OFF_W     = ADDR_WIDTH - SLAVE_SEL_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    rsp_state_e       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             pend_reg, pend_next;
    logic             write_reg, write_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [3:0]       lanes_reg, lanes_next;

    logic [OFF_W-1:0]      offset;
    logic                  accept;
    logic                  legal;
    logic                  complete;
    logic [3:0]            mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_ok;

    assign offset    = bus.haddr[OFF_W-1:0];
    assign accept    = bus.hselx && bus.hready && bus.htrans[1];
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0],
                         bus.haddr[ADDR_WIDTH-1:OFF_W]};

    always_comb begin
        legal = 1'b1;
        if ((offset >> (IDX_W + 2)) != '0)                       legal = 1'b0;
        if (bus.hsize > HSIZE_WORD)                               legal = 1'b0;
        if (bus.hsize == HSIZE_HALF && bus.haddr[0])              legal = 1'b0;
        if (bus.hsize == HSIZE_WORD && bus.haddr[1:0] != 2'b00)   legal = 1'b0;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            write_reg <= 1'b0;
            idx_reg   <= '0;
            lanes_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            write_reg <= write_next;
            idx_reg   <= idx_next;
            lanes_reg <= lanes_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        write_next = write_reg;
        idx_next   = idx_reg;
        lanes_next = lanes_reg;

        // pend_reg marks a legal transfer whose data phase is still owed.
        complete      = pend_reg && (state_reg == ST_IDLE || state_reg == ST_DONE);
        bus.hreadyout = !(state_reg == ST_WAIT || state_reg == ST_ERR1);
        bus.hresp     = (state_reg == ST_ERR1 || state_reg == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        bus.hrdata    = (complete && !write_reg) ? mem_rdata : '0;
        mem_we        = (complete && write_reg) ? lanes_reg : 4'b0000;

        case (state_reg)
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = ST_DONE;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next = ST_IDLE;
                pend_next  = 1'b0;
                if (accept) begin
                    pend_next  = legal;
                    write_next = bus.hwrite;
                    idx_next   = offset[IDX_W+1:2];
                    lanes_next = byte_lanes(bus.hsize, bus.haddr[1:0]);
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
        endcase
    end

    ahb_sram_byte_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .hclk   (hclk),
        .hreset (hreset),
        .we     (mem_we),
        .addr   (idx_reg),
        .wdata  (bus.hwdata),
        .rdata  (mem_rdata)
    );

endmodule
